inference_scheduler: RTL and testbench

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

---
 rtl/inference_scheduler_if.sv | 41 ++++
 rtl/inference_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_inference_scheduler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inference_scheduler_if.sv
// Bundle of the scheduler's control, weight-ROM, pixel-source and network
// signals. The master modport is the scheduler side and the slave modport is
// the surrounding environment (ROM, pixel source, network, host).
interface inference_scheduler_if #(
    parameter int BitSize      = 8,
    parameter int M_W_BitSize  = 8,
    parameter int MaxNumNerves = 8,
    parameter int NumLayers    = 4,
    parameter int WRows        = 8
);
    localparam int AddrW = $clog2(NumLayers * WRows);
    localparam int WordW = MaxNumNerves * M_W_BitSize;

    logic                 start;
    logic                 wt_rd_en;
    logic [AddrW-1:0]     wt_addr;
    logic [WordW-1:0]     wt_rd_data;
    logic                 px_valid;
    logic [BitSize-1:0]   px_data;
    logic                 px_ready;
    logic                 cnn_ready;
    logic                 cnn_in_valid;
    logic [BitSize-1:0]   cnn_in_data;
    logic [WordW-1:0]     cnn_weights;
    logic [NumLayers-1:0] cnn_load_weights;
    logic                 cnn_done;
    logic                 busy;
    logic                 run_done;

    modport master (
        input  start, wt_rd_data, px_valid, px_data, cnn_ready, cnn_done,
        output wt_rd_en, wt_addr, px_ready, cnn_in_valid, cnn_in_data,
               cnn_weights, cnn_load_weights, busy, run_done
    );

    modport slave (
        output start, wt_rd_data, px_valid, px_data, cnn_ready, cnn_done,
        input  wt_rd_en, wt_addr, px_ready, cnn_in_valid, cnn_in_data,
               cnn_weights, cnn_load_weights, busy, run_done
    );
endinterface

// File: rtl/inference_scheduler.sv
// Inference scheduler: loads every layer's weight words from a ROM into the
// network, streams one image of pixels through, waits for the network result
// and then idles for a flush period before signalling completion.
// Optional feature: define SCHED_SKIP_RELOAD_EN to keep weights loaded across
// runs, so that a start after the first completed LOAD goes straight to STREAM.
module inference_scheduler #(
    parameter int BitSize      = 8,
    parameter int M_W_BitSize  = 8,
    parameter int MaxNumNerves = 8,
    parameter int NumLayers    = 4,
    parameter int WRows        = 8,
    parameter int NumPixels    = 256,
    parameter int FlushCycles  = 19
) (
    input logic clk,
    input logic res_n,
    inference_scheduler_if.master bus
);
    localparam int NumWords = NumLayers * WRows;
    localparam int AddrW    = $clog2(NumWords);
    localparam int WordW    = MaxNumNerves * M_W_BitSize;
    localparam int LayerW   = (NumLayers > 1) ? $clog2(NumLayers) : 1;
    localparam int PixW     = $clog2(NumPixels + 1);
    localparam int FlushW   = $clog2(FlushCycles + 1);

    localparam logic [AddrW-1:0]  LastAddr  = AddrW'(NumWords - 1);
    localparam logic [PixW-1:0]   LastPix   = PixW'(NumPixels - 1);
    localparam logic [PixW-1:0]   PixTerm   = PixW'(NumPixels);
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(FlushCycles);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT,
        FLUSH
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [AddrW-1:0]    addr;
    logic                rd_done;
    logic                rd_en;
    logic                load_valid;
    logic [LayerW-1:0]   load_layer;
    logic [PixW-1:0]     pix_count;
    logic [FlushW-1:0]   flush_count;
    logic                run_done_q;
    logic                accept;
    logic                skip_load;

    assign accept = (state == STREAM) && bus.px_valid && bus.cnn_ready;

`ifdef SCHED_SKIP_RELOAD_EN
    logic loaded;

    // Remember that the network holds a full weight set once LOAD completes
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            loaded <= 1'b0;
        end else if (state == LOAD && rd_done) begin
            loaded <= 1'b1;
        end
    end

    assign skip_load = loaded;
`else
    assign skip_load = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and ROM read strobe
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = skip_load ? STREAM : LOAD;
                end
            end
            LOAD: begin
                if (rd_done) begin
                    next_state = STREAM;
                end else begin
                    rd_en = 1'b1;
                end
            end
            STREAM: begin
                if (accept && pix_count == LastPix) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (bus.cnn_done) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_count == '0) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Weight address sequencing: restart at 0 on a loading start, then hold at the last word
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            addr    <= '0;
            rd_done <= 1'b0;
        end else if (state == IDLE) begin
            rd_done <= 1'b0;
            if (bus.start && !skip_load) begin
                addr <= '0;
            end
        end else if (rd_en) begin
            if (addr == LastAddr) begin
                rd_done <= 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

    // Track which layer the ROM word arriving this cycle belongs to
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            load_valid <= 1'b0;
            load_layer <= '0;
        end else begin
            load_valid <= rd_en;
            if (rd_en) begin
                load_layer <= LayerW'(int'(addr) / WRows);
            end
        end
    end

    // Count accepted pixels for the current image, saturating at the image size
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pix_count <= '0;
        end else if (state == IDLE) begin
            pix_count <= '0;
        end else if (accept && pix_count != PixTerm) begin
            pix_count <= pix_count + 1'b1;
        end
    end

    // Flush countdown started by the network result, saturating at zero
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            flush_count <= '0;
        end else if (state == WAIT && bus.cnn_done) begin
            flush_count <= FlushLoad;
        end else if (state == FLUSH && flush_count != '0) begin
            flush_count <= flush_count - 1'b1;
        end
    end

    // Completion pulse coincides with the first IDLE cycle so busy falls together with it
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            run_done_q <= 1'b0;
        end else begin
            run_done_q <= (state == FLUSH) && (flush_count == '0);
        end
    end

    assign bus.wt_rd_en         = rd_en;
    assign bus.wt_addr          = addr;
    assign bus.cnn_weights      = load_valid ? bus.wt_rd_data : WordW'(0);
    assign bus.cnn_load_weights = load_valid ? (NumLayers'(1) << load_layer) : NumLayers'(0);
    assign bus.px_ready         = (state == STREAM) && bus.cnn_ready;
    assign bus.cnn_in_valid     = accept;
    assign bus.cnn_in_data      = (state == STREAM) ? bus.px_data : BitSize'(0);
    assign bus.busy             = (state != IDLE);
    assign bus.run_done         = run_done_q;
endmodule

// File: tb/tb_inference_scheduler.sv
// Self-checking bench for inference_scheduler. A ROM model answers reads one
// cycle late; expectations come from a simple per-run phase model (word index
// during loading, accepted-pixel count during streaming, cycle count during
// the wait/flush tail).
module tb_inference_scheduler;
    localparam int NumWords    = 32;
    localparam int WRows       = 8;
    localparam int NumPixels   = 256;
    localparam int FlushCycles = 19;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] rom [NumWords];

    inference_scheduler_if bus ();

    inference_scheduler dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock; the ROM returns the word addressed in the previous cycle
    task automatic tick();
        logic       en_q;
        logic [4:0] a_q;
        en_q = bus.wt_rd_en;
        a_q  = bus.wt_addr;
        @(posedge clk);
        #1;
        if (en_q) bus.wt_rd_data = rom[a_q];
        else      bus.wt_rd_data = {$urandom(), $urandom()};
    endtask

    task automatic test_reset();
        logic [85:0] outs;
        res_n = 1'b0;
        bus.start = 1'b1; bus.px_valid = 1'b1; bus.cnn_ready = 1'b1; bus.cnn_done = 1'b1;
        bus.px_data = 8'($urandom());
        bus.wt_rd_data = {$urandom(), $urandom()};
        tick();
        tick();
        #1;
        outs = {bus.wt_rd_en, bus.wt_addr, bus.px_ready, bus.cnn_in_valid, bus.cnn_in_data,
                bus.cnn_weights, bus.cnn_load_weights, bus.busy, bus.run_done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", outs);
        end
        bus.start = 1'b0; bus.cnn_done = 1'b0;
        tick();
        res_n = 1'b1;
        tick();
        #1;
        checks++;
        if ({bus.busy, bus.wt_rd_en, bus.px_ready, bus.run_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy/rd_en/px_ready/run_done=%b, required 0000",
                     {bus.busy, bus.wt_rd_en, bus.px_ready, bus.run_done});
        end
    endtask

    task automatic test_load();
        logic        exp_en;
        logic [63:0] exp_w;
        logic [3:0]  exp_l;
        for (int i = 0; i < NumWords; i++) rom[i] = {$urandom(), $urandom()};
        bus.px_valid = 1'b1; bus.cnn_ready = 1'b1; bus.cnn_done = 1'b0; bus.start = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_idle_busy: got %b, required 0", bus.busy);
        end
        for (int k = 0; k <= NumWords; k++) begin
            tick();
            bus.start    = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.cnn_done = 1'($urandom_range(0, 1));
            #1;
            exp_en = (k < NumWords);
            exp_w  = (k > 0) ? rom[k-1] : 64'd0;
            exp_l  = (k > 0) ? 4'(1 << ((k - 1) / WRows)) : 4'd0;
            checks++;
            if (bus.wt_rd_en !== exp_en || (exp_en && bus.wt_addr !== 5'(k))) begin
                errors++;
                $display("[TB] FAIL load_read word %0d: rd_en=%b addr=%0d, required rd_en=%b addr=%0d",
                         k, bus.wt_rd_en, bus.wt_addr, exp_en, k);
            end
            checks++;
            if (bus.cnn_weights !== exp_w) begin
                errors++;
                $display("[TB] FAIL load_weights step %0d: got %h, required %h", k, bus.cnn_weights, exp_w);
            end
            checks++;
            if (bus.cnn_load_weights !== exp_l) begin
                errors++;
                $display("[TB] FAIL load_strobe step %0d: got %b, required %b", k, bus.cnn_load_weights, exp_l);
            end
            checks++;
            if ({bus.busy, bus.px_ready, bus.cnn_in_valid, bus.run_done} !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL load_side step %0d: busy/px_ready/in_valid/run_done=%b, required 1000",
                         k, {bus.busy, bus.px_ready, bus.cnn_in_valid, bus.run_done});
            end
        end
        bus.start = 1'b0; bus.cnn_done = 1'b0;
    endtask

    task automatic test_stream(input int stop_at);
        int         accepted = 0;
        int         pulses = 0;
        int         cycles = 0;
        logic       ready_t = 1'b0;
        logic       valid_t;
        logic [7:0] pd;
        logic       exp_v;
        while (accepted < stop_at && cycles < 3000) begin
            tick();
            cycles++;
            ready_t = ~ready_t;
            valid_t = ($urandom_range(0, 3) != 0);
            pd      = 8'($urandom());
            bus.cnn_ready = ready_t;
            bus.px_valid  = valid_t;
            bus.px_data   = pd;
            bus.start     = 1'($urandom_range(0, 1));
            bus.cnn_done  = 1'($urandom_range(0, 1));
            #1;
            exp_v = valid_t && ready_t;
            checks++;
            if ({bus.px_ready, bus.cnn_in_valid} !== {ready_t, exp_v}) begin
                errors++;
                $display("[TB] FAIL stream_handshake pixel %0d: px_ready/in_valid=%b, required %b",
                         accepted, {bus.px_ready, bus.cnn_in_valid}, {ready_t, exp_v});
            end
            checks++;
            if (bus.cnn_in_data !== pd) begin
                errors++;
                $display("[TB] FAIL stream_data pixel %0d: got %h, required %h", accepted, bus.cnn_in_data, pd);
            end
            checks++;
            if ({bus.busy, bus.wt_rd_en, bus.wt_addr, bus.cnn_weights, bus.cnn_load_weights, bus.run_done}
                    !== {1'b1, 1'b0, 5'd31, 64'd0, 4'd0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stream_side pixel %0d: busy=%b rd_en=%b addr=%0d w=%h ld=%b done=%b, required busy=1 addr=31 rest 0",
                         accepted, bus.busy, bus.wt_rd_en, bus.wt_addr, bus.cnn_weights,
                         bus.cnn_load_weights, bus.run_done);
            end
            if (bus.cnn_in_valid === 1'b1) pulses++;
            if (exp_v) accepted++;
        end
        checks++;
        if (accepted < stop_at) begin
            errors++;
            $display("[TB] FAIL stream_timeout: accepted %0d, required %0d", accepted, stop_at);
        end
        if (stop_at == NumPixels) begin
            tick();
            bus.start = 1'b0; bus.cnn_done = 1'b0; bus.cnn_ready = 1'b1; bus.px_valid = 1'b1;
            #1;
            checks++;
            if ({bus.px_ready, bus.cnn_in_valid, bus.busy} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL wait_entry: px_ready/in_valid/busy=%b, required 001",
                         {bus.px_ready, bus.cnn_in_valid, bus.busy});
            end
            checks++;
            if (pulses !== NumPixels) begin
                errors++;
                $display("[TB] FAIL stream_pulses: got %0d, required %0d", pulses, NumPixels);
            end
        end
    endtask

    task automatic test_wait_flush();
        logic exp_busy;
        logic exp_done;
        for (int w = 1; w <= 5; w++) begin
            tick();
            bus.cnn_done  = (w == 5);
            bus.start     = 1'($urandom_range(0, 1));
            bus.cnn_ready = 1'($urandom_range(0, 1));
            bus.px_valid  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({bus.busy, bus.px_ready, bus.cnn_in_valid, bus.wt_rd_en, bus.run_done} !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL wait_hold cycle %0d: busy/px_ready/in_valid/rd_en/done=%b, required 10000",
                         w, {bus.busy, bus.px_ready, bus.cnn_in_valid, bus.wt_rd_en, bus.run_done});
            end
        end
        // n counts edges from the one that captured cnn_done
        for (int n = 1; n <= FlushCycles + 3; n++) begin
            tick();
            bus.cnn_done = 1'b0;
            if (n == 1)                    bus.start = 1'b1;
            else if (n <= FlushCycles + 1) bus.start = 1'($urandom_range(0, 1));
            else                           bus.start = 1'b0;
            #1;
            exp_busy = (n <= FlushCycles + 1);
            exp_done = (n == FlushCycles + 2);
            checks++;
            if ({bus.run_done, bus.busy} !== {exp_done, exp_busy}) begin
                errors++;
                $display("[TB] FAIL flush_timing edge %0d: run_done/busy=%b, required %b",
                         n, {bus.run_done, bus.busy}, {exp_done, exp_busy});
            end
            checks++;
            if (bus.wt_rd_en !== 1'b0 || bus.wt_addr !== 5'd31) begin
                errors++;
                $display("[TB] FAIL flush_addr edge %0d: rd_en=%b addr=%0d, required rd_en=0 addr=31",
                         n, bus.wt_rd_en, bus.wt_addr);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [85:0] outs;
        test_load();
        test_stream(100);
        bus.start = 1'b0; bus.cnn_done = 1'b0; bus.cnn_ready = 1'b1; bus.px_valid = 1'b1;
        #1;
        checks++;
        if (bus.px_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midstream_ready: got %b, required 1", bus.px_ready);
        end
        res_n = 1'b0;
        #1;
        outs = {bus.wt_rd_en, bus.wt_addr, bus.px_ready, bus.cnn_in_valid, bus.cnn_in_data,
                bus.cnn_weights, bus.cnn_load_weights, bus.busy, bus.run_done};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL midstream_reset_outputs: got %h, required 0", outs);
        end
        tick();
        tick();
        res_n = 1'b1;
    endtask

`ifdef SCHED_SKIP_RELOAD_EN
    task automatic test_back_to_back();
        bus.cnn_ready = 1'b1; bus.px_valid = 1'b0; bus.start = 1'b1;
        #1;
        tick();
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.wt_rd_en, bus.busy, bus.px_ready} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL skip_stream_entry: rd_en/busy/px_ready=%b, required 011",
                     {bus.wt_rd_en, bus.busy, bus.px_ready});
        end
        test_stream(NumPixels);
        test_wait_flush();
    endtask
`else
    task automatic test_back_to_back();
        test_load();
        test_stream(NumPixels);
        test_wait_flush();
    endtask
`endif

    initial begin
        $display("[TB] inference_scheduler bench start");
        test_reset();
        test_reset_midstream();
        test_load();
        test_stream(NumPixels);
        test_wait_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
